// File: rtl/call_stack_if.sv
// Command/status bundle for the hardware call/return stack.
// master: CPU side, drives push/pop/flush/clear_err/data_in and observes status.
// slave : stack side, consumes commands and presents data_out/count/empty/full
//         and the sticky overflow/underflow flags.
interface call_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             flush;
    logic             clear_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, flush, clear_err, data_in,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, clear_err, data_in,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack.sv
// Parametrised call/return stack holding return addresses for the PC-select path.
// Ports: clk, rst_n (async active-low) and bus (call_stack_if.slave) carrying
// push/pop/flush/clear_err/data_in in and data_out/count/empty/full/overflow/
// underflow out. data_out is a same-cycle read of the registered top entry.
// OVF_MODE: 0 = a push while full is rejected, 1 = it overwrites the oldest entry.
module call_stack #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned OVF_MODE = 0
) (
    input logic        clk,
    input logic        rst_n,
    call_stack_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    tp_q, tp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we;
    logic [PW-1:0]    waddr;

    // Next-state decode; flush beats push/pop, and error sets beat clear_err.
    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = tp_q;

        if (bus.clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (bus.flush) begin
            tp_d    = '0;
            count_d = '0;
        end else if (bus.push && bus.pop && !empty_q) begin
            // Replace top in place: no pointer move, no flag even when full.
            we = 1'b1;
        end else if (bus.push) begin
            // Also covers push+pop on an empty stack, which acts as a plain push.
            if (!full_q) begin
                tp_d    = tp_q + PW'(1);
                waddr   = tp_d;
                we      = 1'b1;
                count_d = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
                if (OVF_MODE != 0) begin
                    // Ring wraps onto the oldest slot; count stays at DEPTH.
                    tp_d  = tp_q + PW'(1);
                    waddr = tp_d;
                    we    = 1'b1;
                end
            end
        end else if (bus.pop) begin
            if (!empty_q) begin
                tp_d    = tp_q - PW'(1);
                count_d = count_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control state; storage itself is deliberately left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= bus.data_in;
        end
    end

    assign bus.data_out  = empty_q ? '0 : mem_q[tp_q];
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: two DEPTH=4 instances (reject and wrap overflow policy).
// Stimulus queues hand-computed expected state; a negedge monitor pops and compares.
module tb_call_stack;
    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] data;
        int          count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    call_stack_if #(.WIDTH(W), .DEPTH(D)) if_rej ();
    call_stack_if #(.WIDTH(W), .DEPTH(D)) if_wrap ();

    call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) u_rej (
        .clk(clk), .rst_n(rst_n), .bus(if_rej)
    );
    call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(if_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h required 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: state is stable between edges, so compare at each falling edge.
    initial begin
        exp_t        e;
        logic [31:0] a_data;
        int          a_count;
        logic        a_empty, a_full, a_ovf, a_unf;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.dut == 0) begin
                    a_data = if_rej.data_out;  a_count = int'(if_rej.count);
                    a_empty = if_rej.empty;    a_full = if_rej.full;
                    a_ovf = if_rej.overflow;   a_unf = if_rej.underflow;
                end else begin
                    a_data = if_wrap.data_out; a_count = int'(if_wrap.count);
                    a_empty = if_wrap.empty;   a_full = if_wrap.full;
                    a_ovf = if_wrap.overflow;  a_unf = if_wrap.underflow;
                end
                chk(e.name, "data_out",  a_data, e.data);
                chk(e.name, "count",     32'(a_count), 32'(e.count));
                chk(e.name, "empty",     32'(a_empty), 32'(e.empty));
                chk(e.name, "full",      32'(a_full), 32'(e.full));
                chk(e.name, "overflow",  32'(a_ovf), 32'(e.ovf));
                chk(e.name, "underflow", 32'(a_unf), 32'(e.unf));
            end
        end
    end

    task automatic expect_state(input int d, input logic [31:0] ed, input int ec,
                                input logic eo, input logic eu, input string nm);
        exp_t e;
        e.dut = d; e.name = nm; e.data = ed; e.count = ec;
        e.empty = (ec == 0); e.full = (ec == int'(D));
        e.ovf = eo; e.unf = eu;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int d, input logic ps, input logic pp, input logic fl,
                         input logic ce, input logic [31:0] din);
        if (d == 0) begin
            if_rej.push = ps; if_rej.pop = pp; if_rej.flush = fl;
            if_rej.clear_err = ce; if_rej.data_in = din;
        end else begin
            if_wrap.push = ps; if_wrap.pop = pp; if_wrap.flush = fl;
            if_wrap.clear_err = ce; if_wrap.data_in = din;
        end
    endtask

    // One command cycle followed by the expected post-edge state.
    task automatic step(input int d, input logic ps, input logic pp, input logic fl,
                        input logic ce, input logic [31:0] din, input logic [31:0] ed,
                        input int ec, input logic eo, input logic eu, input string nm);
        @(negedge clk);
        drive(d, ps, pp, fl, ce, din);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_state(d, ed, ec, eo, eu, nm);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        expect_state(0, 32'h0, 0, 1'b0, 1'b0, "reset_rej");
        expect_state(1, 32'h0, 0, 1'b0, 1'b0, "reset_wrap");
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, "idle");

        // LIFO order
        step(0, 1, 0, 0, 0, 32'h100, 32'h100, 1, 0, 0, "lifo_push0");
        step(0, 1, 0, 0, 0, 32'h104, 32'h104, 2, 0, 0, "lifo_push1");
        step(0, 1, 0, 0, 0, 32'h108, 32'h108, 3, 0, 0, "lifo_push2");
        step(0, 0, 1, 0, 0, 32'h0,   32'h104, 2, 0, 0, "lifo_pop0");
        step(0, 0, 1, 0, 0, 32'h0,   32'h100, 1, 0, 0, "lifo_pop1");
        step(0, 0, 1, 0, 0, 32'h0,   32'h0,   0, 0, 0, "lifo_pop2");

        // Reject overflow
        for (int i = 1; i <= 4; i++)
            step(0, 1, 0, 0, 0, 32'(i), 32'(i), i, 0, 0, $sformatf("rej_push%0d", i));
        step(0, 1, 0, 0, 0, 32'h5, 32'h4, 4, 1, 0, "rej_push5_full");
        step(0, 0, 1, 0, 0, 32'h0, 32'h3, 3, 1, 0, "rej_pop0");
        step(0, 0, 1, 0, 0, 32'h0, 32'h2, 2, 1, 0, "rej_pop1");
        step(0, 0, 1, 0, 0, 32'h0, 32'h1, 1, 1, 0, "rej_pop2");
        step(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0, "rej_pop3");
        step(0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0, "rej_clear");

        // Wrap overflow
        for (int i = 1; i <= 4; i++)
            step(1, 1, 0, 0, 0, 32'(i), 32'(i), i, 0, 0, $sformatf("wrap_push%0d", i));
        step(1, 1, 0, 0, 0, 32'h5, 32'h5, 4, 1, 0, "wrap_push5");
        step(1, 1, 0, 0, 0, 32'h6, 32'h6, 4, 1, 0, "wrap_push6");
        step(1, 0, 1, 0, 0, 32'h0, 32'h5, 3, 1, 0, "wrap_pop0");
        step(1, 0, 1, 0, 0, 32'h0, 32'h4, 2, 1, 0, "wrap_pop1");
        step(1, 0, 1, 0, 0, 32'h0, 32'h3, 1, 1, 0, "wrap_pop2");
        step(1, 0, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0, "wrap_pop3");
        step(1, 0, 1, 0, 0, 32'h0, 32'h0, 0, 1, 1, "wrap_underflow");
        step(1, 0, 1, 0, 1, 32'h0, 32'h0, 0, 0, 1, "wrap_set_beats_clear");
        step(1, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0, "wrap_clear");

        // Underflow, clear and replace
        step(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 1, "unf_set");
        step(0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0, "unf_clear");
        step(0, 1, 0, 0, 0, 32'hA, 32'hA, 1, 0, 0, "rep_push_a");
        step(0, 1, 1, 0, 0, 32'hB, 32'hB, 1, 0, 0, "rep_replace_b");
        step(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, "rep_pop");
        step(0, 1, 1, 0, 0, 32'hC, 32'hC, 1, 0, 0, "rep_pushpop_empty");
        step(0, 1, 0, 0, 0, 32'h2, 32'h2, 2, 0, 0, "rep_fill2");
        step(0, 1, 0, 0, 0, 32'h3, 32'h3, 3, 0, 0, "rep_fill3");
        step(0, 1, 0, 0, 0, 32'h4, 32'h4, 4, 0, 0, "rep_fill4");
        step(0, 1, 1, 0, 0, 32'hD, 32'hD, 4, 0, 0, "rep_replace_full");
        step(0, 1, 0, 0, 0, 32'hE, 32'hD, 4, 1, 0, "rep_reject_full");

        // Flush keeps flags, then async reset between edges
        step(0, 1, 0, 1, 0, 32'hF,  32'h0,  0, 1, 0, "flush_push");
        step(0, 1, 0, 0, 0, 32'h20, 32'h20, 1, 1, 0, "post_flush_push0");
        step(0, 1, 0, 0, 0, 32'h21, 32'h21, 2, 1, 0, "post_flush_push1");
        @(posedge clk);
        #2 rst_n = 1'b0;
        expect_state(0, 32'h0, 0, 1'b0, 1'b0, "async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 1, 0, 0, 0, 32'h30, 32'h30, 1, 0, 0, "post_reset_push");

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
